sequence_display: RTL and testbench
===================================

# sequence_display

Playback engine for the Simon Says game: on `start` it walks the stored pattern from step 0 to `seq_len`-1 and shows each step on the board LEDs for a fixed on-time, followed by a dark gap. It then pulses `display_done` so the game controller can arm the player-input path. It is the output-side counterpart of the switch-capture path: it drives the values that the player later reproduces on `sw[3:0]`.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum pattern length (steps); `step_addr` width is $clog2(MAX_LEN).
- `ON_CYCLES`, 25_000_000: clock cycles each step is lit (≥1).
- `OFF_CYCLES`, 12_500_000: clock cycles of dark gap after each step (≥1).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces reset values immediately.
- `on_off`  in  1  game enable; low aborts playback and holds IDLE.
- `start`  in  1  begin playback; sampled only in IDLE.
- `seq_len`  in  $clog2(MAX_LEN+1)  number of steps to show; latched at start.
- `step_addr`  out  $clog2(MAX_LEN)  index into the pattern memory.
- `step_data`  in  4  pattern value at `step_addr`; asynchronous-read memory, valid in the same cycle.
- `led`  out  10  `led[3:0]` = current step while lit, `led[9:4]` always 0.
- `busy`  out  1  high in every state except IDLE.
- `display_done`  out  1  one-cycle pulse at the end of playback.

## Operation
- States: IDLE, FETCH, ON, OFF, DONE.
- IDLE: `led`=0. `start`&&`on_off` → latch `len`=min(`seq_len`,MAX_LEN), `idx`=0; if `len`==0 → DONE, else → FETCH.
- FETCH (1 cycle): `step_addr`=`idx`; on exit, capture `step_data` into the step register, load the timer with ON_CYCLES, → ON.
- ON: `led[3:0]`=captured value; after ON_CYCLES cycles load OFF_CYCLES and → OFF. A captured value of 0 is not skipped: the step plays dark for its full duration.
- OFF: `led`=0; after OFF_CYCLES cycles: if `idx`==`len`-1 → DONE, else `idx`++ → FETCH.
- DONE (1 cycle): `display_done`=1, `led`=0, → IDLE.
- `start` outside IDLE is ignored, and a new `seq_len` has no effect after it is latched.
- `on_off` low in any state → IDLE at the next edge: `led`=0, no `display_done` pulse, `idx` cleared.
- `idx` never exceeds MAX_LEN-1. `step_addr` holds its last value outside FETCH.
- `reset` mid-operation → reset values asynchronously; no pulse is produced on release.

## Timing
- Reset values: `led`=0, `busy`=0, `display_done`=0, `step_addr`=0, state IDLE, timer 0.
- `led`, `display_done` and `step_addr` are registered. `busy` is decoded from state.
- Edge E0 samples `start`. Step k (k from 0) is lit from edge E0+1+k·P through edge E0+1+k·P+ON_CYCLES, where P = 1+ON_CYCLES+OFF_CYCLES.
- `display_done` is high for the one cycle following edge E0+N·P, for N = latched `len` ≥ 1.
- For `len`==0, `display_done` is high in the cycle after E0.
- Earliest accepted restart is the edge after the DONE cycle.
- The timer is a down-counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1). The phase ends when the counter reaches 1 (loaded value N gives exactly N cycles).

## Structure
- Shared `simon_pkg`: `disp_state_t` enum (IDLE/FETCH/ON/OFF/DONE), `LED_W`=10, `STEP_W`=4. `MAX_LEN` is shared with the pattern memory and the comparator.
- One sub-module, `display_timer`: a loadable down-counter with `load`, `value` and `expire` signals, reused for both the ON and the OFF phase.

## Test plan
- ON_CYCLES=4, OFF_CYCLES=2, `seq_len`=3, memory 0001/0100/1000, `start` at E0 → `led[3:0]`=0001 for edges 1–5, 0100 for edges 8–12, 1000 for edges 15–19; `display_done` high after edge 21 only.
- `seq_len`=0, `start` → `busy` high for 1 cycle, `display_done` in the cycle after E0, `led` stays 0.
- `start` re-pulsed and `seq_len` changed during ON of step 1 → timing and length unchanged, exactly one `display_done`.
- `on_off` dropped during OFF of step 0 → IDLE at the next edge, `led`=0, `busy`=0, no `display_done`. A fresh `start` replays from `step_addr`=0.
- `reset` asserted mid-ON (between edges) → `led`=0 and `busy`=0 immediately. After release, no activity until `start`.
- MAX_LEN=16, `seq_len`=20 → exactly 16 steps, `step_addr` sequence 0..15, `display_done` after 16·P edges.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: pattern geometry, LED width and the
// playback FSM state type.
package simon_pkg;
  localparam int SIMON_MAX_LEN = 16;
  localparam int LED_W         = 10;
  localparam int STEP_W        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ON    = 3'd2,
    OFF   = 3'd3,
    DONE  = 3'd4
  } disp_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/display_timer.sv
// Loadable down-counter shared by the lit and dark phases; a loaded value N
// makes expire rise on the Nth cycle after the load.
module display_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = value;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == W'(1));
endmodule

// File: rtl/sequence_display.sv
// Simon Says playback engine: walks the stored pattern, lighting each step
// for ON_CYCLES then a dark gap of OFF_CYCLES, and pulses display_done.
module sequence_display
  import simon_pkg::*;
#(
  parameter int MAX_LEN    = SIMON_MAX_LEN,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         on_off,
  input  logic                         start,
  input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  output logic [$clog2(MAX_LEN)-1:0]   step_addr,
  input  logic [STEP_W-1:0]            step_data,
  output logic [LED_W-1:0]             led,
  output logic                         busy,
  output logic                         display_done
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int TW = $clog2(max2(ON_CYCLES, OFF_CYCLES) + 1);

  disp_state_t       state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expire;

  display_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    led_d    = led_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!on_off) begin
      // Abort: go dark and park the timer so a later start begins clean.
      state_d  = IDLE;
      idx_d    = '0;
      led_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          led_d = '0;
          if (start) begin
            len_d = (int'(seq_len) > MAX_LEN) ? LW'(MAX_LEN) : seq_len;
            idx_d = '0;
            if (len_d == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
              addr_d  = '0;
            end
          end
        end
        FETCH: begin
          led_d    = LED_W'(step_data);
          tmr_load = 1'b1;
          tmr_val  = TW'(ON_CYCLES);
          state_d  = ON;
        end
        ON: begin
          if (tmr_expire) begin
            led_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(OFF_CYCLES);
            state_d  = OFF;
          end
        end
        OFF: begin
          if (tmr_expire) begin
            if (LW'(idx_q) == len_q - LW'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + AW'(1);
              addr_d  = idx_q + AW'(1);
              state_d = FETCH;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign step_addr    = addr_q;
  assign led          = led_q;
  assign display_done = done_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_sequence_display.sv
// Bench for sequence_display with short phases; expected playback is
// derived from step/period arithmetic on the latched length.
module tb_sequence_display;
  localparam int ML   = 16;
  localparam int ONC  = 4;
  localparam int OFFC = 2;
  localparam int P    = 1 + ONC + OFFC;

  logic       clk = 1'b0;
  logic       reset, on_off, start;
  logic [4:0] seq_len;
  logic [3:0] step_addr, step_data;
  logic [9:0] led;
  logic       busy, display_done;
  logic [3:0] mem [ML];

  int nchk = 0, nfail = 0;
  int done_t, done_cnt, last_addr;

  typedef struct {
    int seq_len;
    int exp_end;
    int exp_last;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;
  assign step_data = mem[step_addr];

  sequence_display #(.MAX_LEN(ML), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC)) dut (
    .clk          (clk),
    .reset        (reset),
    .on_off       (on_off),
    .start        (start),
    .seq_len      (seq_len),
    .step_addr    (step_addr),
    .step_data    (step_data),
    .led          (led),
    .busy         (busy),
    .display_done (display_done)
  );

  task automatic chk(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
    end
  endtask

  // t counts edges after the start-sampling edge E0; samples at negedge.
  task automatic play(input int len_in, input int dist_t, input int abort_t);
    int L, e;
    logic [31:0] el;
    bit ab;
    L = (len_in > ML) ? ML : len_in;
    e = L * P;
    done_t = -1; done_cnt = 0; last_addr = -1;
    @(negedge clk);
    seq_len = 5'(len_in);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t <= e + 3; t++) begin
      @(negedge clk);
      ab = (abort_t >= 0) && (t >= abort_t);
      if (ab) el = 0;
      else if (t >= 1 && (t-1)/P < L && (t-1)%P < ONC) el = 32'(mem[(t-1)/P]);
      else el = 0;
      chk("led", t, 32'(led), el);
      chk("busy", t, 32'(busy), 32'(!ab && t <= e));
      chk("done", t, 32'(display_done), 32'(!ab && t == e));
      if (!ab && L > 0 && t <= e)
        chk("step_addr", t, 32'(step_addr), 32'((t/P < L) ? t/P : L-1));
      if (display_done === 1'b1) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
        last_addr = int'(step_addr);
      end
      if (t == dist_t) begin
        start = 1'b1;
        seq_len = 5'(len_in + 2);
      end
      if (t == abort_t - 1) on_off = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      on_off = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3, 21, 2};
    tbl[1] = '{0, 0, -1};
    tbl[2] = '{1, 7, 0};
    tbl[3] = '{16, 112, 15};
    tbl[4] = '{20, 112, 15};
    tbl[5] = '{31, 112, 15};
    for (int i = 0; i < ML; i++) mem[i] = 4'(i + 1);
    reset = 1'b1; on_off = 1'b1; start = 1'b0; seq_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_led", 0, 32'(led), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(display_done), 0);
    chk("rst_addr", 0, 32'(step_addr), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reference pattern 0001/0100/1000
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    play(3, -1, -1);
    chk("ref_done_t", 0, 32'(done_t), 21);
    chk("ref_done_cnt", 0, 32'(done_cnt), 1);

    // Table of lengths including zero and clamping past MAX_LEN
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < ML; j++) mem[j] = 4'($urandom);
      play(tbl[i].seq_len, -1, -1);
      chk("tbl_done_t", i, 32'(done_t), 32'(tbl[i].exp_end));
      chk("tbl_done_cnt", i, 32'(done_cnt), 1);
      if (tbl[i].exp_last >= 0)
        chk("tbl_last_addr", i, 32'(last_addr), 32'(tbl[i].exp_last));
    end

    // start re-pulse and seq_len change during ON of step 1
    play(3, 9, -1);
    chk("dist_done_t", 0, 32'(done_t), 21);
    chk("dist_done_cnt", 0, 32'(done_cnt), 1);

    // on_off dropped during OFF of step 0, then fresh replay
    play(3, -1, 6);
    chk("abort_done_cnt", 0, 32'(done_cnt), 0);
    play(3, -1, -1);
    chk("replay_done_t", 0, 32'(done_t), 21);

    // asynchronous reset in the middle of a lit step
    mem[0] = 4'hA;
    @(negedge clk); seq_len = 5'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_led", 2, 32'(led), 32'hA);
    #2 reset = 1'b1;
    #1;
    chk("arst_led", 0, 32'(led), 0);
    chk("arst_busy", 0, 32'(busy), 0);
    chk("arst_done", 0, 32'(display_done), 0);
    chk("arst_addr", 0, 32'(step_addr), 0);
    @(negedge clk); reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("post_rst_busy", t, 32'(busy), 0);
      chk("post_rst_led", t, 32'(led), 0);
      chk("post_rst_done", t, 32'(display_done), 0);
    end

    // Randomized patterns and lengths
    repeat (20) begin
      int ln;
      for (int j = 0; j < ML; j++) mem[j] = 4'($urandom);
      ln = int'($urandom_range(0, 20));
      play(ln, -1, -1);
      chk("rnd_done_cnt", ln, 32'(done_cnt), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
